// File: rtl/stlc_pkg.sv
// Shared types and lamp constants for the two-approach intersection scheduler.
// PED_WALK is only reachable when the design is built with STLC_PED_EN.
package stlc_pkg;

    typedef enum logic [2:0] {
        ALL_RED  = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        PED_WALK = 3'd5
    } state_e;

    typedef enum logic {
        ROAD_A = 1'b0,
        ROAD_B = 1'b1
    } road_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Every state other than the road's own green/yellow shows red.
    function automatic logic [2:0] lamp_for(input state_e st, input road_e road);
        logic [2:0] lamp;
        lamp = LAMP_RED;
        if (road == ROAD_A) begin
            if (st == A_GREEN)  lamp = LAMP_GRN;
            if (st == A_YELLOW) lamp = LAMP_YEL;
        end else begin
            if (st == B_GREEN)  lamp = LAMP_GRN;
            if (st == B_YELLOW) lamp = LAMP_YEL;
        end
        return lamp;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter: clears on a state change, otherwise counts up,
// and flags when the count has reached the caller-selected limit.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ge_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign ge_o  = (cnt_q >= limit_i);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road junction scheduler: green/yellow/all-red sequencing with latched
// sensor requests and round-robin tie-break. STLC_PED_EN adds a walk phase.
module intersection_scheduler
    import stlc_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int CNT_W     = 6
`ifdef STLC_PED_EN
    ,
    parameter int PED_T     = 10
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sens_a,
    input  logic       sens_b,
`ifdef STLC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic [2:0] phase,
    output logic [1:0] req_pend
);

    state_e           state_q, state_d;
    road_e            last_q, last_d;
    logic             req_a_q, req_a_d;
    logic             req_b_q, req_b_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             limit_hit;
    logic             max_hit;
    state_e           veh_next;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_d != state_q),
        .limit_i (limit),
        .cnt_o   (cnt),
        .ge_o    (limit_hit)
    );

    assign max_hit = (cnt >= CNT_W'(GREEN_MAX - 1));

    always_comb begin
        limit = CNT_W'(ALLRED_T - 1);
        case (state_q)
            A_GREEN, B_GREEN:   limit = CNT_W'(GREEN_MIN - 1);
            A_YELLOW, B_YELLOW: limit = CNT_W'(YELLOW_T - 1);
`ifdef STLC_PED_EN
            PED_WALK:           limit = CNT_W'(PED_T - 1);
`endif
            default:            limit = CNT_W'(ALLRED_T - 1);
        endcase
    end

    // Vehicle choice out of all-red; ties go to the road served less recently.
    always_comb begin
        veh_next = ALL_RED;
        if (req_a_q && req_b_q)
            veh_next = (last_q == ROAD_A) ? B_GREEN : A_GREEN;
        else if (req_a_q)
            veh_next = A_GREEN;
        else if (req_b_q)
            veh_next = B_GREEN;
    end

`ifdef STLC_PED_EN
    logic ped_q, ped_d;

    always_comb begin
        ped_d = ped_q;
        if (ped_req) ped_d = 1'b1;
        if (state_d == PED_WALK && state_q != PED_WALK) ped_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ped_q <= 1'b0;
        else        ped_q <= ped_d;
    end

    assign walk = (state_q == PED_WALK);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ALL_RED: begin
                if (limit_hit) begin
`ifdef STLC_PED_EN
                    state_d = ped_q ? PED_WALK : veh_next;
`else
                    state_d = veh_next;
`endif
                end
            end
            A_GREEN:  if (limit_hit && req_b_q && (!sens_a || max_hit)) state_d = A_YELLOW;
            A_YELLOW: if (limit_hit) state_d = ALL_RED;
            B_GREEN:  if (limit_hit && req_a_q && (!sens_b || max_hit)) state_d = B_YELLOW;
            B_YELLOW: if (limit_hit) state_d = ALL_RED;
`ifdef STLC_PED_EN
            PED_WALK: if (limit_hit) state_d = ALL_RED;
`endif
            default:  state_d = ALL_RED;
        endcase
    end

    // Clearing on green entry outranks a sensor still asserted that cycle.
    always_comb begin
        req_a_d = req_a_q;
        req_b_d = req_b_q;
        last_d  = last_q;
        if (sens_a && state_q != A_GREEN) req_a_d = 1'b1;
        if (sens_b && state_q != B_GREEN) req_b_d = 1'b1;
        if (state_d == A_GREEN && state_q != A_GREEN) begin
            req_a_d = 1'b0;
            last_d  = ROAD_A;
        end
        if (state_d == B_GREEN && state_q != B_GREEN) begin
            req_b_d = 1'b0;
            last_d  = ROAD_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALL_RED;
            last_q  <= ROAD_B;
            req_a_q <= 1'b0;
            req_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            req_a_q <= req_a_d;
            req_b_q <= req_b_d;
        end
    end

    assign light_a  = lamp_for(state_q, ROAD_A);
    assign light_b  = lamp_for(state_q, ROAD_B);
    assign phase    = state_q;
    assign req_pend = {req_b_q, req_a_q};

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler (default build): expected phase transitions
// are queued by the stimulus and checked by a negedge monitor.
module tb_intersection_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sens_a = 1'b0;
    logic       sens_b = 1'b0;
    logic [2:0] light_a, light_b, phase;
    logic [1:0] req_pend;

    // {phase[2:0], lamp_a[2:0], lamp_b[2:0], dwell[7:0]}; dwell 8'hFF = don't care
    logic [16:0] exp_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en = 1'b0;
    logic [2:0] prev_phase = 3'd0;
    int   dwell_cnt = 0;

    intersection_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sens_a   (sens_a),
        .sens_b   (sens_b),
        .light_a  (light_a),
        .light_b  (light_b),
        .phase    (phase),
        .req_pend (req_pend)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [2:0] ph, input int dwell);
        logic [2:0] la, lb;
        logic [7:0] d;
        la = 3'b100;
        lb = 3'b100;
        case (ph)
            3'd1: la = 3'b001;
            3'd2: la = 3'b010;
            3'd3: lb = 3'b001;
            3'd4: lb = 3'b010;
            default: ;
        endcase
        d = (dwell < 0) ? 8'hFF : 8'(dwell);
        return {ph, la, lb, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] ph, input int dwell);
        exp_q.push_back(mk(ph, dwell));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 just after release.
    task automatic do_reset(input bit expect_change, input int dwell);
        if (expect_change) push(3'd0, dwell);
        rst_n  = 1'b0;
        sens_a = 1'b0;
        sens_b = 1'b0;
        #1;
        chk("rst_light_a", 32'(light_a), 32'h4);
        chk("rst_light_b", 32'(light_b), 32'h4);
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_req_pend", 32'(req_pend), 32'h0);
        cycles(2);
        rst_n = 1'b1;
    endtask

    // Monitor: safety check every cycle, scoreboard pop on every phase change.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (light_a != 3'b100 && light_b != 3'b100) begin
                n_fail++;
                $display("FAIL both_non_red: light_a=%b light_b=%b at %0t", light_a, light_b, $time);
            end
            if (phase != prev_phase) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_transition: %0d -> %0d at %0t", prev_phase, phase, $time);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("tr_phase", 32'(phase), 32'(e[16:14]));
                    chk("tr_light_a", 32'(light_a), 32'(e[13:11]));
                    chk("tr_light_b", 32'(light_b), 32'(e[10:8]));
                    if (e[7:0] != 8'hFF) chk("tr_dwell", 32'(dwell_cnt), 32'(e[7:0]));
                end
                prev_phase <= phase;
                dwell_cnt = 1;
            end else begin
                dwell_cnt++;
            end
        end
    end

    initial begin
        // Power-on reset and rest-in-red with no sensors.
        #2;
        chk("por_light_a", 32'(light_a), 32'h4);
        chk("por_light_b", 32'(light_b), 32'h4);
        cycles(3);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            chk("rest_phase", 32'(phase), 32'h0);
            chk("rest_req_pend", 32'(req_pend), 32'h0);
        end

        // Single-cycle A pulse from rest; green then holds with no B demand.
        push(3'd1, -1);
        sens_a = 1'b1;
        cycles(1);
        sens_a = 1'b0;
        chk("pulse_req_latched", 32'(req_pend), 32'h1);
        cycles(1);
        chk("pulse_a_green", 32'(phase), 32'h1);
        chk("pulse_req_cleared", 32'(req_pend), 32'h0);
        cycles(40);
        chk("a_green_hold", 32'(phase), 32'h1);

        // Gap-out at minimum green: 8 green, 3 yellow, 2 all-red, then B.
        do_reset(1'b1, -1);
        push(3'd1, -1);
        sens_a = 1'b1;
        cycles(1);
        sens_a = 1'b0;
        cycles(2);
        sens_b = 1'b1;
        cycles(1);
        sens_b = 1'b0;
        push(3'd2, 8);
        push(3'd0, 3);
        push(3'd3, 2);
        cycles(11);
        chk("gap_b_green", 32'(phase), 32'h3);
        chk("gap_req_cleared", 32'(req_pend), 32'h0);
        cycles(20);
        chk("b_green_hold", 32'(phase), 32'h3);

        // Max-out with sens_a held, then B gaps out back to A.
        do_reset(1'b1, -1);
        push(3'd1, -1);
        sens_a = 1'b1;
        cycles(3);
        sens_b = 1'b1;
        cycles(1);
        sens_b = 1'b0;
        push(3'd2, 32);
        push(3'd0, 3);
        push(3'd3, 2);
        push(3'd4, 8);
        push(3'd0, 3);
        push(3'd1, 2);
        cycles(48);
        chk("maxout_back_to_a", 32'(phase), 32'h1);
        chk("maxout_req_pend", 32'(req_pend), 32'h0);
        cycles(10);
        chk("maxout_a_hold", 32'(phase), 32'h1);
        sens_a = 1'b0;

        // Simultaneous demand: A first (tie), then alternating max-outs.
        do_reset(1'b1, -1);
        push(3'd1, -1);
        push(3'd2, 32);
        push(3'd0, 3);
        push(3'd3, 2);
        push(3'd4, 32);
        push(3'd0, 3);
        push(3'd1, 2);
        push(3'd2, 32);
        sens_a = 1'b1;
        sens_b = 1'b1;
        cycles(2);
        chk("tie_a_first", 32'(phase), 32'h1);
        cycles(107);
        chk("tie_second_a_yellow", 32'(phase), 32'h2);

        // Reset one cycle into A_YELLOW, then stay in red with no sensors.
        do_reset(1'b1, 1);
        cycles(30);
        chk("post_rst_phase", 32'(phase), 32'h0);
        chk("post_rst_req_pend", 32'(req_pend), 32'h0);
        chk("post_rst_light_a", 32'(light_a), 32'h4);
        chk("post_rst_light_b", 32'(light_b), 32'h4);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
